// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Fetch-stage control: program load into instruction memory, then
//            run / single-step / halt of the pipeline front end.
//            Optional single-step support: define FETCH_SEQ_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_cmd,
  input  logic              step_cmd,
  input  logic [31:0]       instruction,
  input  logic              branch_taken,
  input  logic              stall_hazard,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              pc_enable,
  output logic              pc_clear,
  output logic              ifid_enable,
  output logic              ifid_flush,
  output logic              halted,
  output logic              load_overflow,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
`ifdef FETCH_SEQ_STEP_EN
    , S_STEP = 3'd6
`endif
  } state_t;

  localparam logic [3:0]        c_drain_last = 4'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_ptr_max    = '1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_full;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_waddr;
  logic [31:0]         r_imem_wdata;
  logic                r_pc_clear;
  logic                r_overflow;
  logic [31:0]         r_cycle_count;
  logic [3:0]          r_drain_cnt;

  logic                w_can_load;
  logic                w_accept;
  logic                w_start;
  logic                w_fetching;
  logic                w_halt_fetch;
  logic                w_count_en;
  logic [ADDR_W-1:0]   w_waddr;
  logic                w_pc_en;
  logic                w_ifid_en;
  logic                w_flush;

  assign w_can_load = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_READY) || (r_state == S_HALT);
  assign w_accept   = load_valid & w_can_load;
  // Any accepted word outside LOAD begins a fresh program at address 0.
  assign w_start    = w_accept & (r_state != S_LOAD);
  assign w_waddr    = w_start ? '0 : r_ptr;

`ifdef FETCH_SEQ_STEP_EN
  assign w_fetching = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_count_en = w_fetching || (r_state == S_DRAIN);
`else
  logic w_unused_step;
  assign w_unused_step = step_cmd;
  assign w_fetching    = (r_state == S_RUN);
  assign w_count_en    = w_fetching || (r_state == S_DRAIN);
`endif

  // A halt fetched alongside a taken branch is on the wrong path.
  assign w_halt_fetch = (instruction == HALT_WORD) && !branch_taken;

  always_comb begin
    w_next    = r_state;
    w_pc_en   = 1'b0;
    w_ifid_en = 1'b0;
    w_flush   = 1'b0;

    if (w_fetching) begin
      if (branch_taken) begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
        w_flush   = 1'b1;
      end else if (!stall_hazard) begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
      end
    end

    case (r_state)
      S_IDLE, S_HALT: begin
        if (w_accept) w_next = load_last ? S_READY : S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && load_last) w_next = S_READY;
      end
      S_READY: begin
        if (w_accept)     w_next = load_last ? S_READY : S_LOAD;
        else if (run_cmd) w_next = S_RUN;
`ifdef FETCH_SEQ_STEP_EN
        else if (step_cmd) w_next = S_STEP;
`endif
      end
      S_RUN: begin
        if (w_halt_fetch) w_next = S_DRAIN;
      end
`ifdef FETCH_SEQ_STEP_EN
      S_STEP: begin
        w_next = w_halt_fetch ? S_DRAIN : S_READY;
      end
`endif
      S_DRAIN: begin
        w_ifid_en = 1'b1;
        w_flush   = 1'b1;
        if (r_drain_cnt == 4'd0) w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_full        <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_waddr  <= '0;
      r_imem_wdata  <= '0;
      r_pc_clear    <= 1'b0;
      r_overflow    <= 1'b0;
      r_cycle_count <= '0;
      r_drain_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_pc_clear <= w_accept & load_last;
      r_imem_we  <= 1'b0;

      if (w_start) r_overflow <= 1'b0;

      // Once the top address is written, further words are swallowed.
      if (w_accept) begin
        if (w_start || !r_full) begin
          r_imem_we    <= 1'b1;
          r_imem_waddr <= w_waddr;
          r_imem_wdata <= load_data;
          if (w_waddr == c_ptr_max) begin
            r_full <= 1'b1;
          end else begin
            r_full <= 1'b0;
            r_ptr  <= w_waddr + 1'b1;
          end
        end else begin
          r_overflow <= 1'b1;
        end
      end

      if (w_start)
        r_cycle_count <= '0;
      else if (w_count_en && (r_cycle_count != 32'hFFFF_FFFF))
        r_cycle_count <= r_cycle_count + 32'd1;

      if ((w_next == S_DRAIN) && (r_state != S_DRAIN))
        r_drain_cnt <= c_drain_last;
      else if ((r_state == S_DRAIN) && (r_drain_cnt != 4'd0))
        r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  assign load_ready    = w_can_load;
  assign imem_we       = r_imem_we;
  assign imem_waddr    = r_imem_waddr;
  assign imem_wdata    = r_imem_wdata;
  assign pc_enable     = w_pc_en;
  assign pc_clear      = r_pc_clear;
  assign ifid_enable   = w_ifid_en;
  assign ifid_flush    = w_flush;
  assign halted        = (r_state == S_HALT);
  assign load_overflow = r_overflow;
  assign cycle_count   = r_cycle_count;

endmodule
`default_nettype wire
